sample_collector: RTL and testbench



---
 rtl/sample_collector_pkg.sv | 38 +++
 rtl/sync_fifo.sv | 58 +++++
 rtl/sample_collector.sv | 127 ++++++++++++
 tb/tb_sample_collector.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_collector_pkg.sv
// Shared constants for the sample collector: register map, response marker,
// FIFO entry layout and CTRL bit positions.
package sample_collector_pkg;

  localparam logic [7:0] ADDR_CTRL      = 8'd0;
  localparam logic [7:0] ADDR_CHAN_MASK = 8'd1;
  localparam logic [7:0] ADDR_FIFO_LO   = 8'd2;
  localparam logic [7:0] ADDR_FIFO_HI   = 8'd3;
  localparam logic [7:0] ADDR_STATUS    = 8'd4;

  localparam int CTRL_RUN_BIT   = 0;
  localparam int CTRL_CLEAR_BIT = 1;

  // {12'hABC, 3'b111}: anything else on bits [15:1] means nobody drove the bus
  localparam logic [14:0] SAMPLE_MARKER = 15'h55E7;

  localparam int CNT_W           = 15;
  localparam int CNT_LSB         = 16;
  localparam int ENTRY_LOST_BIT  = 31;
  localparam int ENTRY_CHAN_LSB  = 8;
  localparam int ENTRY_VALUE_BIT = 0;

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic logic [31:0] make_entry(input logic       lost,
                                             input cnt_t       cnt,
                                             input logic [7:0] chan,
                                             input logic       value);
    logic [31:0] e;
    e                           = '0;
    e[ENTRY_LOST_BIT]           = lost;
    e[CNT_LSB +: CNT_W]         = cnt;
    e[ENTRY_CHAN_LSB +: 8]      = chan;
    e[ENTRY_VALUE_BIT]          = value;
    return e;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, 2^AW entries. A push into a full FIFO is accepted only
// when a pop happens in the same cycle; clear beats push and pop.
module sync_fifo #(
  parameter int W  = 32,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          empty_q;
  logic          do_push, do_pop;

  assign full    = count_q[AW];
  assign do_pop  = pop & ~empty_q & ~clear;
  assign do_push = push & (~full | do_pop) & ~clear;
  assign count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};

  // NOTE: all clocked state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      empty_q <= (count_d == '0);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count decide
  // which words are meaningful, and a reset here would block RAM inference.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = empty_q;

endmodule

// File: rtl/sample_collector.sv
// Polls enabled channels on the shared sample bus, queues samples whose count
// changed, and exposes the queue through a 16-bit EBI register window.
module sample_collector
  import sample_collector_pkg::*;
#(
  parameter logic [7:0] POSITION     = 8'd240,
  parameter int         NUM_CHANNELS = 32,
  parameter int         FIFO_AW      = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [18:0] addr,
  input  logic        data_wr,
  input  logic        data_rd,
  input  logic [31:0] data_in,
  output logic [15:0] data_out,
  output logic        output_sample,
  output logic [7:0]  channel_select,
  input  logic [31:0] sample_data,
  output logic        fifo_not_empty
);

  localparam int              IDX_W    = 5;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);

  logic             run_q, overflow_q, output_sample_q, resp_pend_q;
  logic [31:0]      mask_q;
  logic [IDX_W-1:0] idx_q, resp_chan_q;
  logic [7:0]       channel_select_q;
  logic [15:0]      data_out_q;
  cnt_t             last_cnt_q [NUM_CHANNELS];

  logic             sel, wr_ctrl, wr_mask, clear, rd_lo;
  logic             marker_ok, is_new, lost, push_req;
  cnt_t             resp_cnt, last_cnt;
  logic [31:0]      entry, fifo_rdata;
  logic [FIFO_AW:0] fifo_count;
  logic             fifo_full, fifo_empty;
  logic             unused_ok;

  assign sel     = enable && (addr[15:8] == POSITION);
  assign wr_ctrl = sel && data_wr && (addr[7:0] == ADDR_CTRL);
  assign wr_mask = sel && data_wr && (addr[7:0] == ADDR_CHAN_MASK);
  assign clear   = wr_ctrl && data_in[CTRL_CLEAR_BIT];
  assign rd_lo   = sel && data_rd && (addr[7:0] == ADDR_FIFO_LO);

  // Response decode is only acted on while resp_pend_q marks a response cycle.
  assign resp_cnt  = sample_data[CNT_LSB +: CNT_W];
  assign marker_ok = (sample_data[15:1] == SAMPLE_MARKER);
  assign last_cnt  = last_cnt_q[resp_chan_q];
  assign is_new    = resp_pend_q && marker_ok && (resp_cnt != last_cnt);
  assign lost      = (resp_cnt != last_cnt + 15'd1);
  assign push_req  = is_new && !clear;
  assign entry     = make_entry(lost, resp_cnt, {{(8-IDX_W){1'b0}}, resp_chan_q},
                                sample_data[ENTRY_VALUE_BIT]);

  sync_fifo #(.W(32), .AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .push  (push_req),
    .pop   (rd_lo),
    .wdata (entry),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q            <= 1'b0;
      mask_q           <= '0;
      overflow_q       <= 1'b0;
      idx_q            <= '0;
      output_sample_q  <= 1'b0;
      channel_select_q <= '0;
      resp_pend_q      <= 1'b0;
      resp_chan_q      <= '0;
      data_out_q       <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) last_cnt_q[i] <= '0;
    end else begin
      data_out_q <= '0;
      if (sel && data_rd) begin
        unique case (addr[7:0])
          ADDR_CHAN_MASK: data_out_q <= mask_q[15:0];
          ADDR_FIFO_LO:   data_out_q <= fifo_empty ? 16'h0 : fifo_rdata[15:0];
          ADDR_FIFO_HI:   data_out_q <= fifo_empty ? 16'h0 : fifo_rdata[31:16];
          ADDR_STATUS:    data_out_q <= {overflow_q, fifo_empty, 14'(fifo_count)};
          default:        data_out_q <= '0;
        endcase
      end

      if (wr_ctrl) run_q  <= data_in[CTRL_RUN_BIT];
      if (wr_mask) mask_q <= data_in;

      if (clear) begin
        idx_q           <= '0;
        output_sample_q <= 1'b0;
        resp_pend_q     <= 1'b0;
        overflow_q      <= 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++) last_cnt_q[i] <= '0;
      end else begin
        if (run_q) begin
          channel_select_q <= {{(8-IDX_W){1'b0}}, idx_q};
          output_sample_q  <= mask_q[idx_q];
          idx_q            <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end else begin
          output_sample_q <= 1'b0;
        end
        // The bus answers one cycle after the strobe.
        resp_pend_q <= output_sample_q;
        resp_chan_q <= channel_select_q[IDX_W-1:0];
        if (is_new) last_cnt_q[resp_chan_q] <= resp_cnt;
        if (push_req && fifo_full && !rd_lo) overflow_q <= 1'b1;
      end
    end
  end

  assign data_out       = data_out_q;
  assign output_sample  = output_sample_q;
  assign channel_select = channel_select_q;
  assign fifo_not_empty = ~fifo_empty;
  assign unused_ok      = ^{addr[18:16], sample_data[31]};

endmodule

// File: tb/tb_sample_collector.sv
// Self-checking bench for sample_collector: a bus responder feeds samples and
// a scoreboard queue predicts the FIFO contents drained through the EBI window.
module tb_sample_collector;

  localparam logic [7:0] POS   = 8'd240;
  localparam int         NCH   = 8;
  localparam int         AW    = 2;
  localparam int         DEPTH = 4;

  localparam logic [7:0] A_CTRL = 8'd0, A_MASK = 8'd1, A_LO = 8'd2,
                         A_HI = 8'd3, A_STATUS = 8'd4;

  logic        clk = 1'b0;
  logic        reset, enable, data_wr, data_rd;
  logic [18:0] addr;
  logic [31:0] data_in, sample_data;
  logic [15:0] data_out;
  logic        output_sample, fifo_not_empty;
  logic [7:0]  channel_select;

  always #5 clk = ~clk;

  sample_collector #(.POSITION(POS), .NUM_CHANNELS(NCH), .FIFO_AW(AW)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .addr           (addr),
    .data_wr        (data_wr),
    .data_rd        (data_rd),
    .data_in        (data_in),
    .data_out       (data_out),
    .output_sample  (output_sample),
    .channel_select (channel_select),
    .sample_data    (sample_data),
    .fifo_not_empty (fifo_not_empty)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] resp_tbl [NCH];
  logic [14:0] m_last [NCH];
  logic [31:0] exp_q [$];
  logic        m_ovf;

  logic        r_pend;
  logic [2:0]  r_ch;
  logic [31:0] r_val;
  logic [14:0] r_nxt;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [14:0] cnt, input logic val);
    return {1'b0, cnt, 12'hABC, 3'b111, val};
  endfunction

  function automatic logic [31:0] exp_status();
    return {16'h0, m_ovf, exp_q.size() == 0, 14'(exp_q.size())};
  endfunction

  task automatic model_flush();
    exp_q.delete();
    m_ovf = 1'b0;
    for (int i = 0; i < NCH; i++) m_last[i] = '0;
  endtask

  // Bus responder: answers one cycle after each strobe and predicts pushes.
  initial begin
    r_pend      = 1'b0;
    r_ch        = '0;
    sample_data = '0;
    forever begin
      @(posedge clk); #1;
      if (r_pend) begin
        r_val       = resp_tbl[r_ch];
        sample_data = r_val;
        if (r_val[15:1] == 15'h55E7 && r_val[30:16] != m_last[r_ch]) begin
          r_nxt = m_last[r_ch] + 15'd1;
          if (exp_q.size() < DEPTH)
            exp_q.push_back({r_val[30:16] != r_nxt, r_val[30:16], 5'b0, r_ch, 7'b0, r_val[0]});
          else
            m_ovf = 1'b1;
          m_last[r_ch] = r_val[30:16];
        end
      end else begin
        sample_data = 32'h0;
      end
      r_pend = output_sample;
      r_ch   = channel_select[2:0];
    end
  end

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    enable = 1'b1; data_wr = 1'b1; addr = {3'b000, POS, a}; data_in = d;
    @(posedge clk); #1;
    enable = 1'b0; data_wr = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [15:0] d);
    @(posedge clk); #1;
    enable = 1'b1; data_rd = 1'b1; addr = {3'b000, POS, a};
    @(posedge clk); #1;
    enable = 1'b0; data_rd = 1'b0;
    d = data_out;
  endtask

  task automatic check_status(input string tag, input logic [15:0] want);
    logic [15:0] d;
    rd(A_STATUS, d);
    check({tag, "_model"}, {16'h0, d}, exp_status());
    check(tag, {16'h0, d}, {16'h0, want});
  endtask

  task automatic read_entry(input string tag, output logic [31:0] got);
    logic [15:0] hi, lo;
    logic [31:0] e;
    rd(A_HI, hi);
    rd(A_LO, lo);
    got = {hi, lo};
    e   = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
    check(tag, got, e);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] got;
    logic [15:0] d;
    logic        found;
    logic [14:0] t3_cnt [4] = '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0002};
    logic [31:0] t3_exp [4] = '{32'hFFFE_0300, 32'h7FFF_0301, 32'h0000_0300, 32'h8002_0301};

    reset = 1'b1; enable = 1'b0; data_wr = 1'b0; data_rd = 1'b0;
    addr = '0; data_in = '0;
    for (int i = 0; i < NCH; i++) resp_tbl[i] = mk(15'd0, 1'b0);
    model_flush();
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out", {16'h0, data_out}, 32'h0);
    check("rst_output_sample", {31'h0, output_sample}, 32'h0);
    check("rst_channel_select", {24'h0, channel_select}, 32'h0);
    check("rst_not_empty", {31'h0, fifo_not_empty}, 32'h0);
    reset = 1'b0;
    check_status("status_after_reset", 16'h4000);

    // Single new sample on channel 0
    wr(A_MASK, 32'h1);
    wr(A_CTRL, 32'h1);
    resp_tbl[0] = mk(15'd1, 1'b1);
    wait_cycles(20);
    check("t1_not_empty", {31'h0, fifo_not_empty}, 32'h1);
    check_status("t1_status", 16'h0001);
    read_entry("t1_entry", got);
    check("t1_entry_const", got, 32'h0001_0001);
    check_status("t1_status_empty", 16'h4000);
    wait_cycles(1);
    check("t1_data_out_idle", {16'h0, data_out}, 32'h0);
    rd(A_MASK, d);
    check("t1_mask_read", {16'h0, d}, 32'h0001);

    // Repeated identical count is not new
    wait_cycles(40);
    check_status("t2_no_repeat", 16'h4000);

    // Channel 3: wrap 7FFF->0 is normal, skip to 2 is lost
    wr(A_MASK, 32'h8);
    for (int i = 0; i < 4; i++) begin
      resp_tbl[3] = mk(t3_cnt[i], i[0]);
      wait_cycles(16);
    end
    check_status("t3_status", 16'h0004);
    for (int i = 0; i < 4; i++) begin
      read_entry("t3_entry", got);
      check("t3_entry_const", got, t3_exp[i]);
    end

    // Overflow with depth 4
    wr(A_MASK, 32'h1);
    for (int i = 2; i <= 6; i++) begin
      resp_tbl[0] = mk(15'(i), 1'b0);
      wait_cycles(16);
    end
    check_status("t4_overflow", 16'h8004);
    read_entry("t4_pop", got);
    check("t4_pop_const", got, 32'h0002_0000);
    resp_tbl[0] = mk(15'd7, 1'b1);
    wait_cycles(16);
    check_status("t4_after_pop", 16'h8004);

    // Marker mismatch is discarded; empty reads return 0
    resp_tbl[0] = 32'hDEAD_BEEF;
    wait_cycles(16);
    check_status("t5_garbage", 16'h8004);
    for (int i = 0; i < 4; i++) read_entry("t5_drain", got);
    check_status("t5_drained", 16'hC000);
    rd(A_LO, d);
    check("t5_empty_lo", {16'h0, d}, 32'h0);
    check_status("t5_after_empty_read", 16'hC000);
    resp_tbl[0] = mk(15'd7, 1'b0);
    wait_cycles(16);
    check_status("t5_last_cnt_kept", 16'hC000);

    // Clear with three entries queued and a response in flight
    for (int i = 8; i <= 10; i++) begin
      resp_tbl[0] = mk(15'(i), 1'b1);
      wait_cycles(16);
    end
    check_status("t6_three", 16'h8003);
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(posedge clk); #1;
      if (output_sample && channel_select == 8'd0) found = 1'b1;
    end
    check("t6_request_seen", {31'h0, found}, 32'h1);
    resp_tbl[0] = mk(15'd11, 1'b1);
    wr(A_CTRL, 32'h3);
    #1;
    model_flush();
    resp_tbl[0] = mk(15'd1, 1'b0);
    check("t6_cleared_flag", {31'h0, fifo_not_empty}, 32'h0);
    wait_cycles(16);
    check_status("t6_after_clear", 16'h0001);
    read_entry("t6_entry", got);
    check("t6_entry_const", got, 32'h0001_0000);

    // Reset in the middle of a scan with a new sample pending
    resp_tbl[0] = mk(15'd2, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #2;
    model_flush();
    reset = 1'b0;
    check("t7_output_sample", {31'h0, output_sample}, 32'h0);
    check("t7_channel_select", {24'h0, channel_select}, 32'h0);
    check("t7_not_empty", {31'h0, fifo_not_empty}, 32'h0);
    wait_cycles(16);
    check("t7_stays_idle", {31'h0, output_sample}, 32'h0);
    check_status("t7_status", 16'h4000);
    rd(A_MASK, d);
    check("t7_mask_reset", {16'h0, d}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
